// File: rtl/ifetch_unit.sv
// rtl/ifetch_unit.sv - instruction fetch unit with one outstanding request and redirect handling
module ifetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] pc,
    output logic [6:0]  opcode,
    output logic [2:0]  fun3,
    output logic        fun7,
    input  logic        redirect_en,
    input  logic [31:0] redirect_pc,
    output logic        fetch_misalign
);

    typedef enum logic [1:0] {RST_WAIT, FETCH, HOLD} state_t;

    state_t      state_q, state_d;
    logic        imem_req_q, imem_req_d;
    logic [31:0] imem_addr_q, imem_addr_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] next_pc_q, next_pc_d;
    logic        instr_valid_q, instr_valid_d;
    logic        drop_q, drop_d;
    logic        misalign_q, misalign_d;
    logic [31:0] redirect_tgt;
    logic        redirect_odd;

    assign redirect_tgt = {redirect_pc[31:2], 2'b00};
    assign redirect_odd = |redirect_pc[1:0];

    always_comb begin
        state_d       = state_q;
        imem_req_d    = imem_req_q;
        imem_addr_d   = imem_addr_q;
        instr_d       = instr_q;
        pc_d          = pc_q;
        next_pc_d     = next_pc_q;
        instr_valid_d = instr_valid_q;
        drop_d        = drop_q;
        misalign_d    = 1'b0;
        case (state_q)
            RST_WAIT: begin
                state_d     = FETCH;
                imem_req_d  = 1'b1;
                imem_addr_d = RESET_PC;
            end
            FETCH: begin
                if (!imem_req_q) begin
                    // Idle gap after a discarded response: nothing outstanding, retarget freely
                    imem_req_d = 1'b1;
                    if (redirect_en) begin
                        imem_addr_d = redirect_tgt;
                        misalign_d  = redirect_odd;
                    end
                end else if (imem_rvalid) begin
                    if (drop_q || redirect_en) begin
                        imem_req_d  = 1'b0;
                        drop_d      = 1'b0;
                        imem_addr_d = redirect_en ? redirect_tgt : next_pc_q;
                        misalign_d  = redirect_en && redirect_odd;
                    end else begin
                        instr_d       = imem_rdata;
                        pc_d          = imem_addr_q;
                        instr_valid_d = 1'b1;
                        imem_req_d    = 1'b0;
                        state_d       = HOLD;
                    end
                end else if (redirect_en) begin
                    next_pc_d  = redirect_tgt;
                    drop_d     = 1'b1;
                    misalign_d = redirect_odd;
                end
            end
            HOLD: begin
                if (redirect_en || instr_ready) begin
                    instr_valid_d = 1'b0;
                    instr_d       = NOP_INSTR;
                    imem_req_d    = 1'b1;
                    imem_addr_d   = redirect_en ? redirect_tgt : pc_q + 32'd4;
                    misalign_d    = redirect_en && redirect_odd;
                    state_d       = FETCH;
                end
            end
            default: state_d = RST_WAIT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= RST_WAIT;
            imem_req_q    <= 1'b0;
            imem_addr_q   <= RESET_PC;
            instr_q       <= NOP_INSTR;
            pc_q          <= RESET_PC;
            next_pc_q     <= RESET_PC;
            instr_valid_q <= 1'b0;
            drop_q        <= 1'b0;
            misalign_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            imem_req_q    <= imem_req_d;
            imem_addr_q   <= imem_addr_d;
            instr_q       <= instr_d;
            pc_q          <= pc_d;
            next_pc_q     <= next_pc_d;
            instr_valid_q <= instr_valid_d;
            drop_q        <= drop_d;
            misalign_q    <= misalign_d;
        end
    end

    assign imem_req       = imem_req_q;
    assign imem_addr      = imem_addr_q;
    assign instr_valid    = instr_valid_q;
    assign instr          = instr_q;
    assign pc             = pc_q;
    assign fetch_misalign = misalign_q;
    assign opcode         = instr_q[6:0];
    assign fun3           = instr_q[14:12];
    assign fun7           = instr_q[30];

endmodule

// File: tb/tb_ifetch_unit.sv
// tb/tb_ifetch_unit.sv - directed scoreboard bench for ifetch_unit
module tb_ifetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [6:0]  opcode;
    logic [2:0]  fun3;
    logic        fun7;
    logic        redirect_en;
    logic [31:0] redirect_pc;
    logic        fetch_misalign;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;
    exp_t sb[$];

    logic        mem_en = 1'b1;
    logic        force_rvalid = 1'b0;
    logic [31:0] force_rdata = 32'h0;
    int          mem_cnt = 0;
    int          mis_cnt = 0;

    ifetch_unit dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .pc             (pc),
        .opcode         (opcode),
        .fun3           (fun3),
        .fun7           (fun7),
        .redirect_en    (redirect_en),
        .redirect_pc    (redirect_pc),
        .fetch_misalign (fetch_misalign)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[24:0], 7'h13} ^ 32'h0000_0080;
    endfunction

    // Two-cycle-latency memory, one response per request
    always @(posedge clk) begin
        #2;
        if (!mem_en) begin
            imem_rvalid = force_rvalid;
            imem_rdata  = force_rdata;
            mem_cnt     = 0;
        end else if (imem_rvalid) begin
            imem_rvalid = 1'b0;
        end else if (imem_req) begin
            mem_cnt++;
            if (mem_cnt >= 2) begin
                imem_rvalid = 1'b1;
                imem_rdata  = mem_word(imem_addr);
                mem_cnt     = 0;
            end
        end else begin
            mem_cnt = 0;
        end
    end

    always @(negedge clk) if (fetch_misalign) mis_cnt++;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [31:0] a);
        exp_t e;
        e.pc    = a;
        e.instr = mem_word(a);
        sb.push_back(e);
    endtask

    task automatic wait_valid(input int max);
        int n = 0;
        while (!instr_valid && n < max) begin
            step();
            n++;
        end
        chk("valid_within_budget", {31'h0, instr_valid}, 32'h1);
    endtask

    task automatic pop_check(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            total++;
            bad++;
            $error("FAIL %s scoreboard empty observed_pc=%h expected=entry", tag, pc);
        end else begin
            e = sb.pop_front();
            chk({tag, "_pc"}, pc, e.pc);
            chk({tag, "_instr"}, instr, e.instr);
            chk({tag, "_opcode"}, {25'h0, opcode}, {25'h0, e.instr[6:0]});
            chk({tag, "_fun3"}, {29'h0, fun3}, {29'h0, e.instr[14:12]});
            chk({tag, "_fun7"}, {31'h0, fun7}, {31'h0, e.instr[30]});
        end
    endtask

    task automatic consume();
        instr_ready = 1'b1;
        step();
        instr_ready = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_req"}, {31'h0, imem_req}, 32'h0);
        chk({tag, "_addr"}, imem_addr, 32'h0);
        chk({tag, "_instr"}, instr, 32'h0000_0013);
        chk({tag, "_pc"}, pc, 32'h0);
        chk({tag, "_valid"}, {31'h0, instr_valid}, 32'h0);
        chk({tag, "_misalign"}, {31'h0, fetch_misalign}, 32'h0);
    endtask

    initial begin
        logic [31:0] held_pc;
        logic [31:0] held_instr;
        int          mis_base;

        rst_n       = 1'b0;
        instr_ready = 1'b0;
        redirect_en = 1'b0;
        redirect_pc = 32'h0;
        step();
        step();
        chk_reset_outputs("reset");

        rst_n = 1'b1;
        step();
        chk("first_req", {31'h0, imem_req}, 32'h1);
        chk("first_addr", imem_addr, 32'h0);
        push(32'h0);
        wait_valid(20);
        chk("first_word", instr, 32'h0000_0093);
        pop_check("first");

        // Stall in HOLD: instr/pc frozen, no request
        held_pc    = pc;
        held_instr = instr;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("hold_valid", {31'h0, instr_valid}, 32'h1);
            chk("hold_req", {31'h0, imem_req}, 32'h0);
            chk("hold_pc", pc, held_pc);
            chk("hold_instr", instr, held_instr);
        end

        consume();
        chk("seq_next_addr", imem_addr, 32'h4);
        chk("seq_next_req", {31'h1 & 31'h0, imem_req}, 32'h1);
        chk("consumed_instr_nop", instr, 32'h0000_0013);
        for (int a = 4; a <= 12; a += 4) begin
            push(a);
            wait_valid(20);
            pop_check("seq");
            consume();
        end

        // Redirect to misaligned target while fetch of 0x10 is outstanding
        chk("pre_redirect_addr", imem_addr, 32'h10);
        mis_base    = mis_cnt;
        redirect_en = 1'b1;
        redirect_pc = 32'h0000_0102;
        step();
        redirect_en = 1'b0;
        chk("misalign_pulse", {31'h0, fetch_misalign}, 32'h1);
        chk("addr_held_outstanding", imem_addr, 32'h10);
        step();
        chk("misalign_one_cycle", {31'h0, fetch_misalign}, 32'h0);
        chk("drop_gap_req", {31'h0, imem_req}, 32'h0);
        chk("drop_new_addr", imem_addr, 32'h100);
        chk("drop_no_valid", {31'h0, instr_valid}, 32'h0);
        push(32'h100);
        wait_valid(20);
        pop_check("redirect");
        chk("misalign_count", mis_cnt - mis_base, 32'h1);

        // Redirect from HOLD to the last word, then wrap
        redirect_en = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        instr_ready = 1'b0;
        step();
        redirect_en = 1'b0;
        chk("hold_redirect_valid", {31'h0, instr_valid}, 32'h0);
        chk("hold_redirect_addr", imem_addr, 32'hFFFF_FFFC);
        chk("hold_redirect_req", {31'h0, imem_req}, 32'h1);
        push(32'hFFFF_FFFC);
        wait_valid(20);
        pop_check("top");
        consume();
        chk("wrap_addr", imem_addr, 32'h0);
        chk("wrap_no_misalign", {31'h0, fetch_misalign}, 32'h0);
        push(32'h0);
        wait_valid(20);
        pop_check("wrap");
        consume();

        // Reset while a request is outstanding; late response must be ignored
        mem_en       = 1'b0;
        force_rvalid = 1'b0;
        chk("pre_reset_req", {31'h0, imem_req}, 32'h1);
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("async_reset");
        force_rvalid = 1'b1;
        force_rdata  = 32'hDEAD_BEEF;
        step();
        step();
        chk("late_rsp_in_reset", {31'h0, instr_valid}, 32'h0);
        rst_n = 1'b1;
        step();
        force_rvalid = 1'b0;
        chk("late_rsp_rst_wait", {31'h0, instr_valid}, 32'h0);
        chk("post_reset_req", {31'h0, imem_req}, 32'h1);
        chk("post_reset_addr", imem_addr, 32'h0);
        mem_en = 1'b1;
        push(32'h0);
        wait_valid(20);
        pop_check("post_reset");
        chk("scoreboard_drained", sb.size(), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
